timer_sched: RTL and testbench
==============================

Name: timer_sched

Overview:
- Four-channel millisecond timer scheduler for the nano6502 CPU bus.
- All four channels share one free-running millisecond prescaler.
- Each channel is a 16-bit down-counter, one-shot or auto-reload, with its own expiry-pending flag.
- A maskable combined IRQ output drives the 6502 IRQ line; the block sits in the peripheral address decode beside the other memory-mapped cores.

Parameters:
- CLK_FRE, 25_175_000, system clock frequency in Hz.
- TICK_DIV, CLK_FRE/1_000, clocks per millisecond tick; must be ≥ 2.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- R_W_n  in  1  CPU read/write; 0 = write
- reg_addr_i  in  4  register select
- data_i  in  8  write data
- timer_cs  in  1  chip select; a write occurs on every clock with timer_cs=1 and R_W_n=0
- data_o  out  8  combinational read data
- irq_o  out  1  registered, level-high interrupt request

Behaviour:
- Register map (read / write):
  - 0x0 STATUS: read {pending[3:0], busy[3:0]}; write bit n=1 starts channel n.
  - 0x1 PENDING: read {4'd0, pending}; write 1s clear those bits (W1C).
  - 0x2 IRQ_EN: read/write bits[3:0]. 0x3 CANCEL: reads 0; write bit n=1 puts channel n in IDLE.
  - 0x4+2n / 0x5+2n: channel n reload LSB / MSB, read/write, in ms.
  - 0xC SNAP: write selects channel data_i[1:0] and captures its live count; read returns snapshot LSB.
  - 0xD: snapshot MSB (read only). 0xE MODE: read/write bits[3:0]; 1 = auto-reload.
  - 0xF and unused bits: read 0, writes ignored.
- Reset: all registers, counts, snapshot, pending, irq_en, mode = 0; all channels IDLE; irq_o=0; prescaler=0.
- Prescaler: counts 0..TICK_DIV-1 and wraps; tick is a 1-cycle pulse at TICK_DIV-1. It is never restarted by software.
- Channel FSM states: IDLE, RUN.
  - IDLE→RUN on start with reload≠0; count←reload.
  - Start with reload=0: channel stays IDLE and pending[n] is set on the next clock.
  - RUN on tick: if count==1, set pending[n]; then if mode[n] count←reload and stay RUN, else go IDLE. Otherwise count←count-1.
  - Start while RUN reloads the count, stays RUN, and leaves pending unchanged.
  - Cancel → IDLE; count is kept for snapshot; pending is unchanged.
- Precedence in one cycle: cancel > start > tick decrement. Expiry set beats a W1C clear of the same bit.
- A write to reload while RUN does not affect the current count; it takes effect at the next reload or start.
- Timing: first expiry falls between reload-1 and reload ms after start (shared-prescaler phase). Auto-reload periods are exactly reload ms.
- busy[n] = (state==RUN). irq_o is registered one clock after |(pending & irq_en).
- Reset asserted mid-count: immediate return to the reset state; no pending flag is set.

Optional Feature:
- Macro: TIMER_SCHED_CHAIN_EN. Bit 4 of MODE (0xE) becomes CHAIN3.
  - When CHAIN3=1, channel 3 decrements on each channel-2 expiry instead of on the ms tick, giving 32-bit delays.
  - Without the macro, MODE bit 4 reads 0 and channel 3 always uses the tick.

Decomposition:
- timer_sched_pkg holds:
  - register address localparams (ADDR_STATUS…ADDR_MODE);
  - channel state encoding (CH_IDLE, CH_RUN);
  - NUM_CH=4.
- Sub-module timer_sched_chan (instantiated 4×):
  - inputs: tick, start, cancel, reload[15:0], auto;
  - outputs: busy, count[15:0], expire pulse.
- Top level holds the prescaler, register file, pending/IRQ logic and read mux.

Test Plan (sim with CLK_FRE=10_000, so TICK_DIV=10):
- Reset: read all 16 addresses → 0x00; irq_o=0.
- One-shot: reload0=3, IRQ_EN=1, start ch0 → busy0 drops and pending0 sets 20–30 clocks after start; irq_o rises 1 clock later; W1C 0x01 to PENDING → irq_o=0.
- Auto-reload: ch1 reload=2, mode=0x02 → pending1 re-sets every 20 clocks after each clear; CANCEL 0x02 → busy1=0, no further expiries.
- Collision: W1C pending2 on the same clock as ch2 expiry → pending2 stays 1.
- Edge cases:
  - start with reload=0 → pending set next clock, busy stays 0;
  - start ch0 while RUN with count=1 → count reloads, no expiry;
  - snapshot of ch0 mid-run reads the live count.
- CHAIN (with TIMER_SCHED_CHAIN_EN): ch2 reload=2 auto, ch3 reload=3, CHAIN3=1 → pending3 after the 3rd ch2 expiry (≈60 clocks).

Source files
------------

// File: rtl/timer_sched_pkg.sv
// timer_sched shared definitions: register map, channel states.
package timer_sched_pkg;

  localparam int NUM_CH = 4;

  localparam logic [3:0] ADDR_STATUS  = 4'h0;
  localparam logic [3:0] ADDR_PENDING = 4'h1;
  localparam logic [3:0] ADDR_IRQ_EN  = 4'h2;
  localparam logic [3:0] ADDR_CANCEL  = 4'h3;
  localparam logic [3:0] ADDR_RELOAD  = 4'h4;
  localparam logic [3:0] ADDR_SNAP_LO = 4'hC;
  localparam logic [3:0] ADDR_SNAP_HI = 4'hD;
  localparam logic [3:0] ADDR_MODE    = 4'hE;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/timer_sched_chan.sv
// timer_sched channel: 16-bit ms down-counter, one-shot or auto-reload.
module timer_sched_chan
  import timer_sched_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick,
  input  logic        start,
  input  logic        cancel,
  input  logic [15:0] reload,
  input  logic        auto,
  output logic        busy,
  output logic [15:0] count,
  output logic        expire
);

  ch_state_e   state_q, state_d;
  logic [15:0] count_q, count_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CH_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    expire  = 1'b0;
    priority case (1'b1)
      cancel: state_d = CH_IDLE;
      start: begin
        if (reload != 16'd0) begin
          state_d = CH_RUN;
          count_d = reload;
        end else begin
          // zero-length delay expires at once
          state_d = CH_IDLE;
          expire  = 1'b1;
        end
      end
      (state_q == CH_RUN) && tick: begin
        if (count_q == 16'd1) begin
          expire = 1'b1;
          if (auto) count_d = reload;
          else      state_d = CH_IDLE;
        end else begin
          count_d = count_q - 16'd1;
        end
      end
      default: ;
    endcase
  end

  assign busy  = (state_q == CH_RUN);
  assign count = count_q;

endmodule

// File: rtl/timer_sched.sv
// Four-channel ms timer scheduler with maskable IRQ.
// Define TIMER_SCHED_CHAIN_EN to chain channel 3 onto channel 2 expiries.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int CLK_FRE  = 25_175_000,
  parameter int TICK_DIV = CLK_FRE / 1_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       R_W_n,
  input  logic [3:0] reg_addr_i,
  input  logic [7:0] data_i,
  input  logic       timer_cs,
  output logic [7:0] data_o,
  output logic       irq_o
);

  localparam int PW = $clog2(TICK_DIV);
`ifdef TIMER_SCHED_CHAIN_EN
  localparam int MW = 5;
`else
  localparam int MW = 4;
`endif

  logic [PW-1:0]     presc_q;
  logic              tick, tick3, wr;
  logic [NUM_CH-1:0] start, cancel, w1c;
  logic [NUM_CH-1:0] busy, expire;
  logic [NUM_CH-2:0] expire_lo;
  logic              expire3;
  logic [NUM_CH-1:0] pending_q, irq_en_q;
  logic [MW-1:0]     mode_q;
  logic [15:0]       snap_q;
  logic [15:0]       reload_q [NUM_CH];
  logic [15:0]       count [NUM_CH];
  logic [1:0]        rsel;

  assign tick   = (presc_q == PW'(TICK_DIV - 1));
  assign wr     = timer_cs & ~R_W_n;
  assign start  = (wr && reg_addr_i == ADDR_STATUS)  ? data_i[3:0] : '0;
  assign cancel = (wr && reg_addr_i == ADDR_CANCEL)  ? data_i[3:0] : '0;
  assign w1c    = (wr && reg_addr_i == ADDR_PENDING) ? data_i[3:0] : '0;

`ifdef TIMER_SCHED_CHAIN_EN
  assign tick3 = mode_q[4] ? expire_lo[2] : tick;
`else
  assign tick3 = tick;
`endif

  for (genvar i = 0; i < NUM_CH - 1; i++) begin : g_ch
    timer_sched_chan u_chan (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .tick   (tick),
      .start  (start[i]),
      .cancel (cancel[i]),
      .reload (reload_q[i]),
      .auto   (mode_q[i]),
      .busy   (busy[i]),
      .count  (count[i]),
      .expire (expire_lo[i])
    );
  end

  timer_sched_chan u_chan3 (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick   (tick3),
    .start  (start[3]),
    .cancel (cancel[3]),
    .reload (reload_q[3]),
    .auto   (mode_q[3]),
    .busy   (busy[3]),
    .count  (count[3]),
    .expire (expire3)
  );

  assign expire = {expire3, expire_lo};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q   <= '0;
      pending_q <= '0;
      irq_en_q  <= '0;
      mode_q    <= '0;
      snap_q    <= '0;
      irq_o     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) reload_q[i] <= '0;
    end else begin
      presc_q   <= tick ? '0 : presc_q + 1'b1;
      // a fresh expiry wins over a same-cycle clear
      pending_q <= (pending_q & ~w1c) | expire;
      irq_o     <= |(pending_q & irq_en_q);
      if (wr && reg_addr_i == ADDR_IRQ_EN)  irq_en_q <= data_i[3:0];
      if (wr && reg_addr_i == ADDR_MODE)    mode_q   <= data_i[MW-1:0];
      if (wr && reg_addr_i == ADDR_SNAP_LO) snap_q   <= count[data_i[1:0]];
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr && reg_addr_i == ADDR_RELOAD + 4'(2 * i))
          reload_q[i][7:0] <= data_i;
        if (wr && reg_addr_i == ADDR_RELOAD + 4'(2 * i + 1))
          reload_q[i][15:8] <= data_i;
      end
    end
  end

  assign rsel = 2'(reg_addr_i[3:1] - 3'd2);

  always_comb begin
    data_o = 8'h00;
    case (reg_addr_i)
      ADDR_STATUS:  data_o = {pending_q, busy};
      ADDR_PENDING: data_o = {4'd0, pending_q};
      ADDR_IRQ_EN:  data_o = {4'd0, irq_en_q};
      ADDR_SNAP_LO: data_o = snap_q[7:0];
      ADDR_SNAP_HI: data_o = snap_q[15:8];
      ADDR_MODE:    data_o = 8'(mode_q);
      default: begin
        if (reg_addr_i >= ADDR_RELOAD && reg_addr_i < ADDR_SNAP_LO)
          data_o = reg_addr_i[0] ? reload_q[rsel][15:8]
                                 : reload_q[rsel][7:0];
      end
    endcase
  end

endmodule

// File: tb/tb_timer_sched.sv
// timer_sched bench: random and directed bus traffic, scoreboarded
// against a ms-level reference model of the register map.
module tb_timer_sched;

  localparam int TDIV = 10;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       R_W_n = 1'b1;
  logic [3:0] reg_addr_i = '0;
  logic [7:0] data_i = '0;
  logic       timer_cs = 1'b0;
  logic [7:0] data_o;
  logic       irq_o;

  timer_sched #(.CLK_FRE(10_000)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .R_W_n      (R_W_n),
    .reg_addr_i (reg_addr_i),
    .data_i     (data_i),
    .timer_cs   (timer_cs),
    .data_o     (data_o),
    .irq_o      (irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit [3:0] a;
    bit [7:0] v;
  } rd_t;

  rd_t rd_q[$];
  bit  irq_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // reference model state (ms-level counters, plain integers)
  int       m_presc;
  bit       m_busy[4];
  int       m_cnt[4];
  int       m_rel[4];
  bit [3:0] m_pend, m_ien;
  bit [4:0] m_mode;
  int       m_snap;
  bit       m_irq;

  task automatic model_reset();
    m_presc = 0; m_pend = '0; m_ien = '0; m_mode = '0;
    m_snap = 0; m_irq = 1'b0;
    for (int n = 0; n < 4; n++) begin
      m_busy[n] = 1'b0; m_cnt[n] = 0; m_rel[n] = 0;
    end
  endtask

  function automatic bit [7:0] model_read(input bit [3:0] a);
    bit [3:0] b;
    for (int n = 0; n < 4; n++) b[n] = m_busy[n];
    case (a)
      4'h0: return {m_pend, b};
      4'h1: return {4'd0, m_pend};
      4'h2: return {4'd0, m_ien};
      4'hC: return 8'(m_snap);
      4'hD: return 8'(m_snap >> 8);
      4'hE: return {3'd0, m_mode};
      4'h3, 4'hF: return 8'h00;
      default: return a[0] ? 8'(m_rel[(a - 4) / 2] >> 8)
                           : 8'(m_rel[(a - 4) / 2]);
    endcase
  endfunction

  task automatic model_step(input bit cs, input bit rw,
                            input bit [3:0] a, input bit [7:0] d);
    bit       wr, tk, t, irq_n;
    bit [3:0] ex;
    int       n;
    wr = cs && !rw;
    tk = (m_presc == TDIV - 1);
    ex = '0;
    irq_n = |(m_pend & m_ien);
    if (wr && a == 4'hC) m_snap = m_cnt[d[1:0]];
    for (int c = 0; c < 4; c++) begin
      t = (c == 3 && m_mode[4]) ? ex[2] : tk;
      if (wr && a == 4'h3 && d[c]) begin
        m_busy[c] = 1'b0;
      end else if (wr && a == 4'h0 && d[c]) begin
        if (m_rel[c] != 0) begin
          m_busy[c] = 1'b1; m_cnt[c] = m_rel[c];
        end else begin
          m_busy[c] = 1'b0; ex[c] = 1'b1;
        end
      end else if (m_busy[c] && t) begin
        if (m_cnt[c] == 1) begin
          ex[c] = 1'b1;
          if (m_mode[c]) m_cnt[c] = m_rel[c];
          else m_busy[c] = 1'b0;
        end else begin
          m_cnt[c] = m_cnt[c] - 1;
        end
      end
    end
    if (wr && a == 4'h1) m_pend = (m_pend & ~d[3:0]) | ex;
    else m_pend = m_pend | ex;
    m_irq = irq_n;
    if (wr && a == 4'h2) m_ien = d[3:0];
`ifdef TIMER_SCHED_CHAIN_EN
    if (wr && a == 4'hE) m_mode = d[4:0];
`else
    if (wr && a == 4'hE) m_mode = {1'b0, d[3:0]};
`endif
    if (wr && a >= 4 && a <= 11) begin
      n = (a - 4) / 2;
      if (a[0]) m_rel[n] = (m_rel[n] & 'hFF) | (int'(d) << 8);
      else m_rel[n] = (m_rel[n] & 'hFF00) | int'(d);
    end
    m_presc = (m_presc + 1) % TDIV;
  endtask

  // drives one bus cycle starting 1 time unit after a rising edge
  task automatic bus(input bit cs, input bit rw,
                     input bit [3:0] a, input bit [7:0] d);
    rd_t r;
    timer_cs = cs; R_W_n = rw; reg_addr_i = a; data_i = d;
    if (cs && rw) begin
      r.a = a; r.v = model_read(a);
      rd_q.push_back(r);
    end
    irq_q.push_back(m_irq);
    @(posedge clk_i);
    model_step(cs, rw, a, d);
    #1;
  endtask

  task automatic wr(input bit [3:0] a, input bit [7:0] d);
    bus(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input bit [3:0] a);
    bus(1'b1, 1'b1, a, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 1'b1, 4'h0, 8'h00);
  endtask

  // run until channel c is in its final ms with a tick this cycle
  task automatic wait_last(input int c, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_busy[c] && m_cnt[c] == 1 && m_presc == TDIV - 1) begin
        found = 1'b1;
        break;
      end
      rd(4'h0);
    end
    if (!found) begin
      n_bad++;
      $display("FAIL %s: expiry window not reached in 200 cycles", tag);
    end
  endtask

  always @(negedge clk_i) begin
    rd_t r;
    bit  e;
    if (irq_q.size() > 0) begin
      e = irq_q.pop_front();
      n_cmp++;
      if (irq_o !== e) begin
        n_bad++;
        $display("FAIL irq_o @%0t: got %b want %b", $time, irq_o, e);
      end
    end
    if (rd_q.size() > 0) begin
      r = rd_q.pop_front();
      n_cmp++;
      if (data_o !== r.v) begin
        n_bad++;
        $display("FAIL read 0x%h @%0t: got 0x%h want 0x%h",
                 r.a, $time, data_o, r.v);
      end
    end
  end

  initial begin
    bit [3:0] a;
    bit [7:0] d;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // reset values
    for (int i = 0; i < 16; i++) rd(4'(i));

    // one-shot ch0, 3 ms, IRQ enabled
    wr(4'h4, 8'd3); wr(4'h5, 8'd0); wr(4'h2, 8'h01); wr(4'h0, 8'h01);
    repeat (35) rd(4'h0);
    wr(4'h1, 8'h01);
    repeat (3) rd(4'h1);

    // auto-reload ch1, 2 ms, clear on every expiry
    wr(4'h6, 8'd2); wr(4'h7, 8'd0); wr(4'hE, 8'h02);
    wr(4'h2, 8'h02); wr(4'h0, 8'h02);
    for (int i = 0; i < 80; i++) begin
      if (m_pend[1]) wr(4'h1, 8'h02);
      else rd(4'h1);
    end
    wr(4'h3, 8'h02);
    repeat (40) rd(4'h0);

    // W1C colliding with ch2 expiry
    wr(4'h1, 8'h0F); wr(4'h8, 8'd1); wr(4'h9, 8'd0); wr(4'h0, 8'h04);
    wait_last(2, "collide");
    wr(4'h1, 8'h04);
    rd(4'h1); rd(4'h0);
    wr(4'h1, 8'h0F);

    // zero reload: immediate pending, never busy
    wr(4'hA, 8'd0); wr(4'h0, 8'h08);
    rd(4'h0); rd(4'h0);
    wr(4'h1, 8'h0F);

    // restart ch0 in its last ms: reload, no expiry
    wr(4'hE, 8'h00); wr(4'h4, 8'd2); wr(4'h0, 8'h01);
    wait_last(0, "restart");
    wr(4'h0, 8'h01);
    repeat (5) rd(4'h0);
    wr(4'h3, 8'h01);

    // live-count snapshot
    wr(4'h4, 8'd5); wr(4'h5, 8'd1); wr(4'h0, 8'h01);
    idle(23);
    wr(4'hC, 8'h00); rd(4'hC); rd(4'hD);
    idle(15);
    wr(4'hC, 8'h00); rd(4'hC); rd(4'hD);
    wr(4'h3, 8'h0F); wr(4'h1, 8'h0F);

`ifdef TIMER_SCHED_CHAIN_EN
    // ch3 counts ch2 expiries
    wr(4'h8, 8'd2); wr(4'h9, 8'd0); wr(4'hA, 8'd3); wr(4'hB, 8'd0);
    wr(4'hE, 8'h14); wr(4'h2, 8'h08); wr(4'h0, 8'h0C);
    repeat (80) rd(4'h1);
    rd(4'hE);
    wr(4'h3, 8'h0F); wr(4'hE, 8'h00); wr(4'h1, 8'h0F);
`endif

    // random traffic, with one asynchronous reset mid-run
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
        model_reset();
      end
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom);
      if (a >= 4 && a <= 11) d = a[0] ? 8'd0 : 8'($urandom_range(0, 4));
      case ($urandom_range(0, 9))
        0, 1, 2: idle(1);
        3, 4, 5, 6: rd(a);
        default: wr(a, d);
      endcase
    end

    idle(2);
    @(negedge clk_i);
    #1;
    n_cmp++;
    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d reads, %0d irq left, want 0",
               rd_q.size(), irq_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
